// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four requesters driving a registered 4:1 data mux.
// Define MUX_ARB_TIMEOUT_EN to add a hold-limit counter that forces handoff after MAX_HOLD cycles.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic [3:0] gnt,
    output logic       sel1,
    output logic       sel2,
    output logic       y,
    output logic       valid,
    output logic       busy
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..15");
    end

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic       y_q, y_d;
    logic       valid_q, valid_d;

    logic       mux_out;
    logic [1:0] winner;
    logic [3:0] others;
    logic       hold_expired;
    logic       release_now;
    logic       new_grant;

`ifdef MUX_ARB_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;
    assign hold_expired = (cnt_q == 4'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
`endif

    // First set bit after 'from', wrapping; 'from' itself is examined last.
    function automatic logic [1:0] rr_pick(input logic [1:0] from, input logic [3:0] r);
        logic [1:0] idx;
        rr_pick = from;
        for (int i = 4; i >= 1; i--) begin
            idx = from + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        mux_out = a;
        case (sel_q)
            2'd0: mux_out = a;
            2'd1: mux_out = b;
            2'd2: mux_out = c;
            2'd3: mux_out = d;
            default: mux_out = a;
        endcase
    end

    assign others      = req & ~(4'b0001 << sel_q);
    assign winner      = rr_pick(last_q, req);
    assign release_now = (state_q == GRANT) &&
                         (!req[sel_q] || (hold_expired && (others != 4'b0000)));
    assign new_grant   = ((state_q == IDLE) && (req != 4'b0000)) ||
                         (release_now && (others != 4'b0000));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            y_q     <= 1'b0;
            valid_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            y_q     <= y_d;
            valid_q <= valid_d;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req != 4'b0000) state_d = GRANT;
            GRANT:   if (release_now && (others == 4'b0000)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        y_d     = mux_out;
        valid_d = (state_q == GRANT) && req[sel_q];
        if (new_grant) begin
            gnt_d  = 4'b0001 << winner;
            sel_d  = winner;
            last_d = winner;
        end else if (state_d == IDLE) begin
            gnt_d = 4'b0000;
        end
`ifdef MUX_ARB_TIMEOUT_EN
        cnt_d = cnt_q;
        if (new_grant) begin
            cnt_d = 4'd0;
        end else if ((state_q == GRANT) && !hold_expired) begin
            cnt_d = cnt_q + 4'd1;
        end
`endif
    end

    assign gnt   = gnt_q;
    assign sel1  = sel_q[1];
    assign sel2  = sel_q[0];
    assign y     = y_q;
    assign valid = valid_q;
    assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed vector table, round-robin and hold-limit sequences,
// and randomized traffic compared against a cycle-level reference model.
module tb_mux_rr_arbiter;

    localparam int MH = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic [3:0] gnt;
    logic       sel1, sel2, y, valid, busy;

    int errors = 0;
    int checks = 0;

    mux_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .d(d),
        .gnt(gnt), .sel1(sel1), .sel2(sel2), .y(y), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: owner index, priority pointer and hold count as plain integers.
    bit         m_grant;
    int         m_sel, m_last, m_cnt;
    logic [3:0] m_gnt;
    logic       m_y, m_valid;

    function automatic int pick(input int from, input logic [3:0] r);
        for (int i = 1; i <= 4; i++) if (r[(from + i) % 4]) return (from + i) % 4;
        return from;
    endfunction

    task automatic m_give(input int w);
        m_grant = 1'b1;
        m_gnt   = 4'(1 << w);
        m_sel   = w;
        m_last  = w;
        m_cnt   = 0;
    endtask

    task automatic model_step(input logic r, input logic [3:0] rq, input logic [3:0] dat);
        logic [3:0] oth;
        bit         expired;
        if (r) begin
            m_grant = 1'b0; m_sel = 0; m_last = 3; m_cnt = 0;
            m_gnt = 4'b0000; m_y = 1'b0; m_valid = 1'b0;
            return;
        end
        m_y     = dat[m_sel];
        m_valid = m_grant && rq[m_sel];
        oth     = rq & ~4'(1 << m_sel);
        if (!m_grant) begin
            if (rq != 4'b0000) m_give(pick(m_last, rq));
        end else begin
            expired = TO && (m_cnt == MH - 1) && (oth != 4'b0000);
            if (!rq[m_sel] || expired) begin
                if (oth != 4'b0000) m_give(pick(m_sel, oth));
                else begin m_grant = 1'b0; m_gnt = 4'b0000; end
            end else if (m_cnt < MH - 1) begin
                m_cnt++;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic [3:0] rq, input logic [3:0] dat);
        @(negedge clk);
        rst = r; req = rq; {d, c, b, a} = dat;
        @(posedge clk);
        model_step(r, rq, dat);
        #1;
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {busy,valid,y,sel,gnt}=%b required %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] dut_out();
        return {busy, valid, y, sel1, sel2, gnt};
    endfunction

    function automatic logic [9:0] model_out();
        return {m_grant, m_valid, m_y, 2'(m_sel), m_gnt};
    endfunction

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] dat;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       y;
        logic       v;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [3:0] rqv, prev, rnd_req, mask;
        logic [3:0] seen[$];
        logic [3:0] exp_g;
        int         held;
        bit         idle_seen;
        logic       r;

        // rst, req, data{d,c,b,a}, gnt, sel, y, valid
        tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 2'b00, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'b0000, 4'b0001, 4'b0000, 2'b00, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 4'b0000, 4'b0100, 4'b0000, 2'b10, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 2'b01, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 4'b1010, 4'b1010, 4'b0010, 2'b01, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 2'b11, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, 2'b11, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 2'b11, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 2'b01, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 4'b0010, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 4'b0011, 4'b0000, 4'b0001, 2'b00, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].rst, tbl[i].req, tbl[i].dat);
            check($sformatf("vec[%0d]", i), dut_out(),
                  {(tbl[i].gnt != 4'b0000), tbl[i].v, tbl[i].y, tbl[i].sel, tbl[i].gnt});
        end

        // Round robin with each owner dropping after two granted cycles.
        cycle(1'b1, 4'b1111, 4'b0000);
        cycle(1'b1, 4'b1111, 4'b0000);
        prev = 4'b0000; held = 0; idle_seen = 1'b0;
        for (int k = 0; k < 40 && seen.size() < 5; k++) begin
            rqv = 4'b1111;
            if (held >= 2) rqv = 4'b1111 & ~gnt;
            cycle(1'b0, rqv, 4'($urandom_range(0, 15)));
            check("rr_model", dut_out(), model_out());
            if (gnt != prev) begin
                if (gnt != 4'b0000) seen.push_back(gnt);
                held = 1;
            end else begin
                held++;
            end
            if (seen.size() > 0 && gnt == 4'b0000) idle_seen = 1'b1;
            prev = gnt;
        end
        checks++;
        if (seen.size() != 5) begin
            errors++;
            $display("FAIL rr_count: got %0d owners required 5 within budget", seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                exp_g = 4'(1 << (i % 4));
                checks++;
                if (seen[i] !== exp_g) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got gnt=%b required %b", i, seen[i], exp_g);
                end
            end
        end
        checks++;
        if (idle_seen) begin
            errors++;
            $display("FAIL rr_no_bubble: got idle cycle=1 required 0");
        end

        // Two requesters held high: hold-limit alternation or indefinite hold.
        cycle(1'b1, 4'b0000, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 4'b0011, 4'($urandom_range(0, 15)));
            exp_g = (TO && ((k / MH) % 2 == 1)) ? 4'b0010 : 4'b0001;
            checks++;
            if (gnt !== exp_g) begin
                errors++;
                $display("FAIL hold[%0d]: got gnt=%b required %b", k, gnt, exp_g);
            end
            check("hold_model", dut_out(), model_out());
        end

        // Randomized traffic with sticky requests and occasional reset.
        cycle(1'b1, 4'b0000, 4'b0000);
        rnd_req = 4'b0000;
        for (int k = 0; k < 500; k++) begin
            mask    = 4'($urandom) & 4'($urandom);
            rnd_req = rnd_req ^ mask;
            r       = ($urandom_range(0, 39) == 0);
            cycle(r, rnd_req, 4'($urandom_range(0, 15)));
            check($sformatf("rand[%0d]", k), dut_out(), model_out());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 4, maximum consecutive grant cycles per owner when another request is pending; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  request vector; req[0]..req[3] belong to requesters a..d.
REQ-005 a, b, c, d  input  1 each  requester data bits, selected by sel1/sel2.
REQ-006 gnt  output  4  one-hot grant vector, registered; all zero when idle.
REQ-007 sel1  output  1  mux select MSB = owner index bit 1, registered.
REQ-008 sel2  output  1  mux select LSB = owner index bit 0, registered.
REQ-009 y  output  1  registered selected data bit.
REQ-010 valid  output  1  registered; qualifies y.
REQ-011 busy  output  1  1 while state is GRANT.

Function
REQ-012 Select map: {sel1,sel2} 00->a, 01->b, 10->c, 11->d; internal 4:1 mux is combinational from registered sel1/sel2.
REQ-013 FSM shall have two states: IDLE (no owner) and GRANT (one owner).
REQ-014 IDLE: if req != 0, the winner is the first set req bit searching from (last+1) mod 4 upward with wrap; next cycle state=GRANT, gnt=onehot(winner), {sel1,sel2}=winner, last=winner.
REQ-015 IDLE with req == 0: remain IDLE, gnt=0, sel1/sel2 hold their previous value.
REQ-016 GRANT, owner req high, no release condition: hold gnt/sel unchanged.
REQ-017 GRANT, owner req low: release; if other req bits set, hand off to the round-robin winner next cycle with no idle bubble (GRANT->GRANT); otherwise next state IDLE, gnt=0.
REQ-018 Each cycle: y <= mux output; valid <= (state==GRANT) && req[owner]; latency from data input to y is exactly 1 cycle.
REQ-019 Requests from non-owners during GRANT shall be ignored until a release; no requester is starved (round-robin guarantees service within 3 grants).
REQ-020 gnt shall never have more than one bit set; gnt and {sel1,sel2} always change on the same edge.
REQ-021 A requester whose grant was just released shall be searched last in the next arbitration.

Reset
REQ-022 On rst=1 at a rising edge: state=IDLE, gnt=0, sel1=0, sel2=0, y=0, valid=0, busy=0, hold counter=0, last=3 (requester a has first priority).
REQ-023 rst asserted mid-grant shall abort the grant on that edge regardless of req; the first arbitration after rst deasserts uses last=3.

Configuration
REQ-024 Macro MUX_ARB_TIMEOUT_EN shall compile in a hold-limit counter (4-bit), cleared on every new grant and incremented each GRANT cycle.
REQ-025 With MUX_ARB_TIMEOUT_EN defined: when counter == MAX_HOLD-1 and any non-owner req is set, the owner is released and the round-robin winner is granted next cycle; if no other req is set, the owner keeps the grant and the counter saturates.
REQ-026 Without MUX_ARB_TIMEOUT_EN: no counter exists, MAX_HOLD is unused, and an owner holds the grant until its req drops.

Verification
REQ-027 Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, sel1=sel2=0, y=0, valid=0; after release first gnt=4'b0001.
REQ-028 Single requester: req=4'b0100, c=1 for 5 cycles -> gnt=4'b0100, {sel1,sel2}=10, y=1 and valid=1 from the cycle after the grant; req=0 -> IDLE and gnt=0 next cycle.
REQ-029 Round robin: req=4'b1111, each owner drops its req after 2 granted cycles -> grant order a,b,c,d,a with no idle cycles between owners.
REQ-030 Handoff: owner b drops req while req[3] is set -> next cycle gnt=4'b1000, sel=11, y follows d one cycle later.
REQ-031 Timeout (MUX_ARB_TIMEOUT_EN, MAX_HOLD=4): req=4'b0011 held high -> a granted 4 cycles, then b 4 cycles, alternating; without the macro, a holds indefinitely.
REQ-032 Reset mid-grant: gnt=4'b0010 with rst=1 for 1 cycle -> all outputs zero next edge; with req=4'b0011 afterwards, a is granted first.
